instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the instruction decode path: packs decoded instruction fields into 32-bit words in the custom ISA format.
- Streams the packed words into instruction memory through a write port, with the memory address auto-incremented from a latched base address.
- Serves as the program loader: fed by a test/boot generator before the core runs.
- A small FIFO decouples field acceptance from memory backpressure.

Parameters:
- ADDR_W, 32, instruction-memory byte address width.
- FIFO_DEPTH, 4, packed-word buffer entries (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begins a load session.
- base_addr  in  ADDR_W  first write address; latched on accepted start.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_last  in  1  bundle is the final instruction of the session.
- fmt  in  2  encoding format: 0=R, 1=M, 2=B, 3=J.
- opcode  in  7  operation code.
- dst_reg  in  5  destination register index.
- src_reg_1  in  5  first source register index.
- src_reg_2  in  5  second source register index.
- mem_offset  in  15  M-type offset.
- brn_offset  in  15  B-type offset.
- jmp_offset  in  20  jump offset.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write byte address.
- imem_wdata  out  32  packed instruction.
- imem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  session active.
- done  out  1  one-cycle pulse when the last word is written.
- word_count  out  16  words written in the current session; saturates at 0xFFFF.

Behaviour:
- Packing (combinational on inputs; stored into the FIFO on accept):
  - All formats: [31:25]=opcode.
  - R: [24:20]=dst, [19:15]=src1, [14:10]=src2, [9:0]=0.
  - M: [24:20]=dst, [19:15]=src1, [14:0]=mem_offset.
  - B: [24:20]=brn_offset[14:10], [19:15]=src1, [14:10]=src2, [9:0]=brn_offset[9:0].
  - J: [24:20]=jmp_offset[19:15], [19:15]=0, [14:0]=jmp_offset[14:0].
  - Fields unused by a format are ignored.
- FSM states: IDLE, RUN, DRAIN, FINISH.
  - IDLE → RUN on start: latch base_addr into the address counter and clear word_count.
  - RUN → DRAIN when a bundle with in_last=1 is accepted.
  - DRAIN → FINISH when the FIFO is empty and no write is pending.
  - FINISH → IDLE after one cycle; done=1 only in FINISH.
- start is ignored outside IDLE.
- in_ready = (state==RUN) && !fifo_full.
  - Bundles offered in IDLE, DRAIN or FINISH are not accepted.
  - A pop in the same cycle does not open a slot for a push.
- Accept = in_valid && in_ready. The packed word is written to the FIFO tail at that edge.
- imem_we = fifo non-empty; imem_wdata = FIFO head; imem_addr = address counter.
- Write completes when imem_we && imem_ready. That edge:
  - pops the FIFO;
  - adds 4 to the address, wrapping modulo 2^ADDR_W;
  - increments word_count.
- imem_we, imem_addr and imem_wdata stay stable while imem_ready=0.
- Latency: a bundle accepted at edge N gives imem_we=1 in the cycle after N, at the earliest.
- Simultaneous push and pop on a non-full FIFO: both happen and the count is unchanged.
- busy=1 in RUN, DRAIN and FINISH.
- Reset values: state=IDLE; FIFO empty; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, word_count=0.
- Reset mid-session: everything clears asynchronously. Buffered words are discarded and no partial write is retried.

Decomposition:
- Format codes (FMT_R, FMT_M, FMT_B, FMT_J) and bit-position constants go in the shared parameters.v, next to the OP_* opcodes, so decoder and encoder share one field map.
- One natural sub-module: sync_fifo (parameterised width and depth, with full/empty and push/pop).

Test Plan:
- R-type: start, base 0x100; fmt=0, op=0x01, dst=3, s1=1, s2=2, last=1; imem_ready=1.
  - Required: one write of 0x02308800 at 0x100, then done pulse, word_count=1.
- M-type: op=0x10, dst=5, s1=6, mem_offset=0x1234 → wdata 0x20531234.
- B-type: op=0x20, s1=1, s2=2, brn_offset=0x7C05 → 0x41F08805.
- J-type: op=0x30, jmp_offset=0xABCDE → 0x61503CDE. Feeding the word to the decoder returns identical fields.
- Backpressure: imem_ready=0, 6 bundles offered.
  - Required: exactly 4 accepted, then in_ready=0 and outputs held stable.
  - After imem_ready=1: all 6 words written in order at consecutive +4 addresses.
- Wrap and reset: ADDR_W=8, base 0xFC, 2 words → addresses 0xFC then 0x00.
  - rst_n low mid-DRAIN → all outputs at reset values immediately, and no done pulse.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared field map for the custom ISA: format codes, bit positions, FSM states
// and the field-to-word packing function used by the instruction encoder.
package instr_encoder_pkg;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_M = 2'd1;
    localparam logic [1:0] FMT_B = 2'd2;
    localparam logic [1:0] FMT_J = 2'd3;

    localparam int OPC_LSB = 25;
    localparam int RD_LSB  = 20;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  dst_reg;
        logic [4:0]  src_reg_1;
        logic [4:0]  src_reg_2;
        logic [14:0] mem_offset;
        logic [14:0] brn_offset;
        logic [19:0] jmp_offset;
    } instr_fields_t;

    // B and J reuse the rd slot for the high offset bits so every format keeps
    // the same rs1/rs2 positions as the decoder expects.
    function automatic logic [31:0] pack_instr(input instr_fields_t f);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: 7] = f.opcode;
        case (f.fmt)
            FMT_R: begin
                w[RD_LSB  +: 5] = f.dst_reg;
                w[RS1_LSB +: 5] = f.src_reg_1;
                w[RS2_LSB +: 5] = f.src_reg_2;
            end
            FMT_M: begin
                w[RD_LSB  +: 5] = f.dst_reg;
                w[RS1_LSB +: 5] = f.src_reg_1;
                w[14:0]         = f.mem_offset;
            end
            FMT_B: begin
                w[RD_LSB  +: 5] = f.brn_offset[14:10];
                w[RS1_LSB +: 5] = f.src_reg_1;
                w[RS2_LSB +: 5] = f.src_reg_2;
                w[9:0]          = f.brn_offset[9:0];
            end
            FMT_J: begin
                w[RD_LSB +: 5] = f.jmp_offset[19:15];
                w[14:0]        = f.jmp_offset[14:0];
            end
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Small synchronous FIFO with full/empty flags; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [AW:0]                 count;
    logic                        do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs decoded fields into ISA words and streams them into
// instruction memory at auto-incrementing addresses from a latched base.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        dst_reg,
    input  logic [4:0]        src_reg_1,
    input  logic [4:0]        src_reg_2,
    input  logic [14:0]       mem_offset,
    input  logic [14:0]       brn_offset,
    input  logic [19:0]       jmp_offset,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_count
);
    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wc_q;
    instr_fields_t     fields;
    logic [31:0]       packed_word, head;
    logic              fifo_full, fifo_empty, accept, wr_done;

    assign fields = '{fmt: fmt, opcode: opcode, dst_reg: dst_reg, src_reg_1: src_reg_1,
                      src_reg_2: src_reg_2, mem_offset: mem_offset, brn_offset: brn_offset,
                      jmp_offset: jmp_offset};
    assign packed_word = pack_instr(fields);

    assign in_ready = (state == ST_RUN) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign imem_we  = !fifo_empty;
    assign wr_done  = imem_we && imem_ready;

    // Mask the head so the write bus reads zero when nothing is buffered.
    assign imem_wdata = fifo_empty ? 32'd0 : head;
    assign imem_addr  = addr_q;
    assign word_count = wc_q;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_FINISH);

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (packed_word),
        .pop   (wr_done),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            wc_q   <= '0;
        end else begin
            if (wr_done) begin
                addr_q <= addr_q + ADDR_W'(4);
                if (wc_q != 16'hFFFF) wc_q <= wc_q + 16'd1;
            end
            case (state)
                ST_IDLE: if (start) begin
                    state  <= ST_RUN;
                    addr_q <= base_addr;
                    wc_q   <= '0;
                end
                ST_RUN:    if (accept && in_last) state <= ST_DRAIN;
                ST_DRAIN:  if (fifo_empty) state <= ST_FINISH;
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: format vectors, backpressure, random
// sessions against a scoreboard, address wrap and mid-session reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n, rst8_n, start, start8;
    logic [31:0] base_addr;
    logic [7:0]  base8;
    logic        in_valid, in_last, imem_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  dst_reg, src_reg_1, src_reg_2;
    logic [14:0] mem_offset, brn_offset;
    logic [19:0] jmp_offset;

    logic        in_ready, imem_we, busy, done;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] word_count;

    logic        in_ready8, we8, busy8, done8;
    logic [7:0]  addr8;
    logic [31:0] wdata8;
    logic [15:0] wc8;

    instr_encoder #(.ADDR_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .fmt(fmt),
        .opcode(opcode), .dst_reg(dst_reg), .src_reg_1(src_reg_1), .src_reg_2(src_reg_2),
        .mem_offset(mem_offset), .brn_offset(brn_offset), .jmp_offset(jmp_offset),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready), .busy(busy), .done(done), .word_count(word_count)
    );

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .base_addr(base8),
        .in_valid(in_valid), .in_ready(in_ready8), .in_last(in_last), .fmt(fmt),
        .opcode(opcode), .dst_reg(dst_reg), .src_reg_1(src_reg_1), .src_reg_2(src_reg_2),
        .mem_offset(mem_offset), .brn_offset(brn_offset), .jmp_offset(jmp_offset),
        .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8),
        .imem_ready(imem_ready), .busy(busy8), .done(done8), .word_count(wc8)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference packing by plain arithmetic on the field values.
    function automatic logic [31:0] model_word();
        logic [63:0] w, op, d, s1, s2, mo, bo, jo;
        op = 64'(opcode); d = 64'(dst_reg); s1 = 64'(src_reg_1); s2 = 64'(src_reg_2);
        mo = 64'(mem_offset); bo = 64'(brn_offset); jo = 64'(jmp_offset);
        w  = op * 64'd33554432;
        case (fmt)
            2'd0:    w = w + d * 64'd1048576 + s1 * 64'd32768 + s2 * 64'd1024;
            2'd1:    w = w + d * 64'd1048576 + s1 * 64'd32768 + mo;
            2'd2:    w = w + (bo / 64'd1024) * 64'd1048576 + s1 * 64'd32768
                         + s2 * 64'd1024 + (bo % 64'd1024);
            default: w = w + (jo / 64'd32768) * 64'd1048576 + (jo % 64'd32768);
        endcase
        return w[31:0];
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] ref_addr;
    int          ref_cnt;
    bit          m_run = 1'b0;
    bit          rand_ready = 1'b0;
    logic [31:0] w8_addr[$];
    logic [31:0] w8_data[$];

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            chk("accept_in_run", 32'(m_run), 32'd1);
            exp_q.push_back(model_word());
            if (in_last) m_run = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            if (exp_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
            else begin
                chk("wdata", imem_wdata, exp_q.pop_front());
                chk("waddr", imem_addr, ref_addr);
            end
            ref_addr = ref_addr + 32'd4;
            ref_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst8_n && we8 && imem_ready) begin
            w8_addr.push_back(32'(addr8));
            w8_data.push_back(wdata8);
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 imem_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        fmt        = 2'($urandom);
        opcode     = 7'($urandom);
        dst_reg    = 5'($urandom);
        src_reg_1  = 5'($urandom);
        src_reg_2  = 5'($urandom);
        mem_offset = 15'($urandom);
        brn_offset = 15'($urandom);
        jmp_offset = 20'($urandom);
    endtask

    task automatic begin_session(input logic [31:0] b);
        start = 1'b1; base_addr = b; ref_addr = b; ref_cnt = 0; m_run = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic offer(input bit last, input bit use8);
        in_valid = 1'b1;
        in_last  = last;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (use8 ? in_ready8 : in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
                chk({tag, "_wc"}, 32'(word_count), 32'(ref_cnt));
                @(negedge clk);
                chk({tag, "_idle"}, 32'(busy), 32'd0);
                tick();
                return;
            end
        end
        chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  d, s1, s2;
        logic [14:0] mo, bo;
        logic [19:0] jo;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[4];

    initial begin
        int n_acc, bad, n;
        bit seen;

        rst_n = 1'b0; rst8_n = 1'b0; start = 1'b0; start8 = 1'b0;
        base_addr = '0; base8 = '0; in_valid = 1'b0; in_last = 1'b0; imem_ready = 1'b1;
        rand_fields();
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        #12 rst_n = 1'b1; rst8_n = 1'b1;
        tick();

        // Unused fields carry junk to show each format ignores them.
        vt[0] = '{2'd0, 7'h01, 5'd3,  5'd1,  5'd2,  15'h7FFF, 15'h7FFF, 20'hFFFFF, 32'h02308800};
        vt[1] = '{2'd1, 7'h10, 5'd5,  5'd6,  5'd31, 15'h1234, 15'h5555, 20'h12345, 32'h20531234};
        vt[2] = '{2'd2, 7'h20, 5'd31, 5'd1,  5'd2,  15'h7FFF, 15'h7C05, 20'hFFFFF, 32'h41F08805};
        vt[3] = '{2'd3, 7'h30, 5'd31, 5'd31, 5'd31, 15'h7FFF, 15'h7FFF, 20'hABCDE, 32'h61503CDE};

        for (int i = 0; i < 4; i++) begin
            begin_session(32'h100 + 32'(i) * 32'h100);
            fmt = vt[i].fmt; opcode = vt[i].op; dst_reg = vt[i].d;
            src_reg_1 = vt[i].s1; src_reg_2 = vt[i].s2; mem_offset = vt[i].mo;
            brn_offset = vt[i].bo; jmp_offset = vt[i].jo;
            offer(1'b1, 1'b0);
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (imem_we) begin
                    seen = 1'b1;
                    chk($sformatf("vec%0d_wdata", i), imem_wdata, vt[i].exp);
                    chk($sformatf("vec%0d_addr", i), imem_addr, 32'h100 + 32'(i) * 32'h100);
                end
            end
            chk($sformatf("vec%0d_write_seen", i), 32'(seen), 32'd1);
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_words", i), 32'(ref_cnt), 32'd1);
        end

        // Backpressure: six bundles offered against a stalled memory.
        imem_ready = 1'b0;
        begin_session(32'h200);
        n_acc = 0;
        rand_fields();
        in_valid = 1'b1; in_last = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (in_ready) n_acc++;
            tick();
            start = (c == 6);
            base_addr = 32'h999;
            if (in_ready || c == 0) begin end
            rand_fields();
            in_last = (n_acc == 5);
        end
        start = 1'b0;
        chk("bp_accepted", 32'(n_acc), 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_we_held", 32'(imem_we), 32'd1);
            chk("bp_wdata_held", imem_wdata, exp_q[0]);
            chk("bp_addr_held", imem_addr, 32'h200);
        end
        tick();
        imem_ready = 1'b1;
        for (int c = 0; c < 40 && n_acc < 6; c++) begin
            @(negedge clk);
            if (in_ready) begin
                n_acc++;
                tick();
                rand_fields();
                in_last = (n_acc == 5);
            end
        end
        chk("bp_all_accepted", 32'(n_acc), 32'd6);
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_drain_in_ready", 32'(in_ready), 32'd0);
        wait_done("bp");
        in_valid = 1'b0;
        chk("bp_words", 32'(ref_cnt), 32'd6);

        // Random sessions against the scoreboard with random memory stalls.
        rand_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            begin_session($urandom);
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                rand_fields();
                offer(k == n - 1, 1'b0);
            end
            wait_done($sformatf("rnd%0d", s));
            chk($sformatf("rnd%0d_words", s), 32'(ref_cnt), 32'(n));
        end
        rand_ready = 1'b0;
        tick();
        imem_ready = 1'b1;

        // Address wrap on an 8-bit address counter.
        start8 = 1'b1; base8 = 8'hFC;
        tick();
        start8 = 1'b0;
        rand_fields();
        w8_data.delete(); w8_addr.delete();
        exp_q.push_back(model_word());
        offer(1'b0, 1'b1);
        rand_fields();
        exp_q.push_back(model_word());
        offer(1'b1, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        chk("wrap_done", 32'(seen), 32'd1);
        chk("wrap_nwrites", 32'(w8_addr.size()), 32'd2);
        if (w8_addr.size() == 2) begin
            chk("wrap_addr0", w8_addr[0], 32'hFC);
            chk("wrap_addr1", w8_addr[1], 32'h00);
            chk("wrap_data0", w8_data[0], exp_q[0]);
            chk("wrap_data1", w8_data[1], exp_q[1]);
        end
        exp_q.delete();
        tick();

        // Reset while draining: everything clears at once and no done follows.
        imem_ready = 1'b0;
        start8 = 1'b1; base8 = 8'h10;
        tick();
        start8 = 1'b0;
        rand_fields();
        offer(1'b0, 1'b1);
        rand_fields();
        offer(1'b1, 1'b1);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy8), 32'd1);
        chk("pre_rst_we", 32'(we8), 32'd1);
        #2 rst8_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready8), 32'd0);
        chk("mid_rst_we", 32'(we8), 32'd0);
        chk("mid_rst_addr", 32'(addr8), 32'd0);
        chk("mid_rst_wdata", wdata8, 32'd0);
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        chk("mid_rst_wc", 32'(wc8), 32'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        imem_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done8 || we8 || busy8) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
